sap_controller: RTL
===================

Name: sap_controller

Overview:
Controller-sequencer for the 4-bit SAP datapath. It owns the one-hot T-state ring counter and decodes the instruction-register opcode into the control word. The control word drives the MAR input mux/strobe and load enables, plus the PC, RAM, IR, accumulator, B register, ALU and output register. It sits beside the datapath, drives every load/output-enable pin, and is the only block that sequences memory-address loads.

Parameters:
NUM_T, 6, number of T-states in the ring (one-hot width); fixed at 6 for this instruction set
OPW, 4, opcode width taken from IR upper nibble

Ports:
clk  in  1  system clock, all state changes on rising edge
clr  in  1  asynchronous active-high reset
ir_opcode  in  OPW  opcode from IR upper nibble; treated as valid from T4 onward
t_state  out  NUM_T  one-hot ring state (debug/visibility)
halted  out  1  high once HLT is executed; held until clr
pc_inc  out  1  Cp: PC increments on next edge
pc_oe  out  1  Ep: PC drives bus
mar_sel  out  1  MAR mux select: 0 = bus, 1 = forced zero
mar_g_n  out  1  MAR mux strobe, active low
mar_ld_n  out  1  MAR load enable (tie to both g1/g2), active low
ram_oe_n  out  1  RAM drives bus, active low
ir_ld_n  out  1  IR load, active low
ir_oe_n  out  1  IR lower nibble (operand) drives bus, active low
acc_ld_n  out  1  accumulator load, active low
acc_oe  out  1  accumulator drives bus
b_ld_n  out  1  B register load, active low
alu_sub  out  1  ALU subtract select
alu_oe  out  1  ALU drives bus
out_ld_n  out  1  output register load, active low

Behaviour:
- Reset (clr high, async): t_state=6'b000001 (T1), halted=0, internal halt flag cleared. Outputs take the T1 decode immediately.
- Ring: each rising edge with halted=0 rotates T1->T2->...->T6->T1. Every instruction takes exactly 6 cycles; no early exit.
- Inactive levels: active-low signals 1, active-high signals 0, mar_sel=0. mar_g_n=0 whenever halted=0.
- Control decode is combinational from registered t_state, halted and ir_opcode. There is no extra latency: the control word is valid for the whole cycle after the edge that entered the state.
- T1 (fetch addr): pc_oe=1, mar_ld_n=0.
- T2 (increment): pc_inc=1.
- T3 (memory): ram_oe_n=0, ir_ld_n=0.
- Opcodes: LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'hE, HLT=4'hF. Any other opcode is a NOP: T4-T6 all inactive.
- T4: LDA/ADD/SUB: ir_oe_n=0, mar_ld_n=0. OUT: acc_oe=1, out_ld_n=0. HLT: halted set on this edge (takes effect from the next cycle).
- T5: LDA: ram_oe_n=0, acc_ld_n=0. ADD/SUB: ram_oe_n=0, b_ld_n=0.
- T6: ADD: alu_oe=1, acc_ld_n=0. SUB: same plus alu_sub=1.
- Halt: ring frozen at T5, every control inactive, mar_g_n=1 (MAR mux tristated), mar_sel=0. Only clr exits.
- Bus exclusivity: at most one of pc_oe, ram_oe_n(low), ir_oe_n(low), acc_oe, alu_oe is asserted in any cycle. This is a hard invariant.
- Reset mid-instruction: async clear wins over any state; partial instruction is abandoned; next cycle is T1.
- Invalid ring state (not one-hot; SEU/X): the next edge forces T1.

Optional Feature:
SAP_STEP_EN. When defined, adds input step (1 bit) and a rising-edge detector register. The ring, and the halt-flag set, advance only on cycles where step is seen rising. Control outputs for a held state stay asserted, except mar_ld_n, ir_ld_n, acc_ld_n, b_ld_n and out_ld_n, which are gated to assert only on the advance cycle; this prevents repeated loads. pc_inc is gated the same way. The edge detector resets to 0 on clr. When not defined, the ring advances every clock and the step port does not exist.

Decomposition:
- Package sap_pkg: opcode localparams (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT), T-state index constants T1..T6, NUM_T, OPW.
- Sub-module sap_ring_counter: one-hot ring with clk, clr, advance, freeze and recovery to T1. The decode stays in sap_controller.

Test Plan:
- Reset then free-run with ir_opcode=4'h0: t_state 000001->000010->...->100000->000001. Check pc_oe/mar_ld_n in T1, pc_inc in T2, ram_oe_n/ir_ld_n low in T3, ir_oe_n/mar_ld_n in T4, ram_oe_n/acc_ld_n in T5, all idle in T6.
- ir_opcode=4'h2 across a full cycle: T5 b_ld_n=0; T6 alu_oe=1, alu_sub=1, acc_ld_n=0. With 4'h1, alu_sub=0 in T6.
- ir_opcode=4'hE: T4 acc_oe=1, out_ld_n=0. ir_opcode=4'h7: T4-T6 all controls inactive.
- ir_opcode=4'hF: halted=1 after the T4 edge; t_state holds 010000 for 20 clocks; mar_g_n=1 and all controls inactive. Pulse clr: halted=0, t_state=000001.
- Assert clr asynchronously mid-T5 between clock edges: t_state=000001 immediately, with no clock required.
- Every cycle of a random opcode stream: assertion that at most one bus driver is active.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared constants for the SAP controller: opcodes, T-state encodings, control word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sap_pkg;

  localparam int NUM_T = 6;
  localparam int OPW   = 4;

  // Bit index of each T-state inside the one-hot ring
  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;

  // Full one-hot encodings, compared whole so a corrupted ring decodes to nothing
  localparam logic [NUM_T-1:0] S_T1 = 6'b000001;
  localparam logic [NUM_T-1:0] S_T2 = 6'b000010;
  localparam logic [NUM_T-1:0] S_T3 = 6'b000100;
  localparam logic [NUM_T-1:0] S_T4 = 6'b001000;
  localparam logic [NUM_T-1:0] S_T5 = 6'b010000;
  localparam logic [NUM_T-1:0] S_T6 = 6'b100000;

  localparam logic [OPW-1:0] OP_LDA = 4'h0;
  localparam logic [OPW-1:0] OP_ADD = 4'h1;
  localparam logic [OPW-1:0] OP_SUB = 4'h2;
  localparam logic [OPW-1:0] OP_OUT = 4'hE;
  localparam logic [OPW-1:0] OP_HLT = 4'hF;

  // Control word, one field per datapath pin
  typedef struct packed {
    logic pc_inc;
    logic pc_oe;
    logic mar_sel;
    logic mar_g_n;
    logic mar_ld_n;
    logic ram_oe_n;
    logic ir_ld_n;
    logic ir_oe_n;
    logic acc_ld_n;
    logic acc_oe;
    logic b_ld_n;
    logic alu_sub;
    logic alu_oe;
    logic out_ld_n;
  } ctrl_t;

  // Every pin at its inactive level with the MAR mux enabled onto the bus
  localparam ctrl_t CTRL_IDLE = '{
    pc_inc:   1'b0,
    pc_oe:    1'b0,
    mar_sel:  1'b0,
    mar_g_n:  1'b0,
    mar_ld_n: 1'b1,
    ram_oe_n: 1'b1,
    ir_ld_n:  1'b1,
    ir_oe_n:  1'b1,
    acc_ld_n: 1'b1,
    acc_oe:   1'b0,
    b_ld_n:   1'b1,
    alu_sub:  1'b0,
    alu_oe:   1'b0,
    out_ld_n: 1'b1
  };

  // True when exactly one bit of the ring is set
  function automatic logic is_onehot(input logic [NUM_T-1:0] v);
    logic [NUM_T-1:0] one;
    one = {{(NUM_T-1){1'b0}}, 1'b1};
    return (v != '0) && ((v & (v - one)) == '0);
  endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot T-state ring: rotates T1..T6, holds while frozen, self-recovers to T1.
// Latency: state changes on the rising edge after advance is seen.
// Backpressure: freeze (halt) and a low advance both hold the current state.
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             advance,
  input  logic             freeze,
  output logic [NUM_T-1:0] t_state
);

  // Rotate one position per advance; a non-one-hot ring is forced back to T1
  // on the next edge even when frozen, so an upset can never lock the sequencer.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      t_state <= S_T1;
    end else if (!is_onehot(t_state)) begin
      t_state <= S_T1;
    end else if (advance && !freeze) begin
      t_state <= {t_state[NUM_T-2:0], t_state[NUM_T-1]};
    end
  end

endmodule

// File: rtl/sap_controller.sv
// SAP controller-sequencer: T-state ring plus opcode decode into the datapath control word.
// Latency: control word is combinational from the registered ring, valid the whole cycle.
// Backpressure: none by default; with SAP_STEP_EN the ring only advances on a rising step.
module sap_controller
  import sap_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
`ifdef SAP_STEP_EN
  input  logic             step,
`endif
  input  logic [OPW-1:0]   ir_opcode,
  output logic [NUM_T-1:0] t_state,
  output logic             halted,
  output logic             pc_inc,
  output logic             pc_oe,
  output logic             mar_sel,
  output logic             mar_g_n,
  output logic             mar_ld_n,
  output logic             ram_oe_n,
  output logic             ir_ld_n,
  output logic             ir_oe_n,
  output logic             acc_ld_n,
  output logic             acc_oe,
  output logic             b_ld_n,
  output logic             alu_sub,
  output logic             alu_oe,
  output logic             out_ld_n
);

  logic  advance;
  logic  ld_gate;
  logic  halt_set;
  ctrl_t ctrl;

`ifdef SAP_STEP_EN
  logic step_q;
  logic step_rise;

  // Remember last step level so only a 0->1 transition advances the ring
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  assign step_rise = step & ~step_q;
  assign advance   = step_rise;
  // Loads and PC increment fire only on the advancing cycle so a held state
  // cannot clock the same register repeatedly.
  assign ld_gate   = step_rise;
`else
  assign advance   = 1'b1;
  assign ld_gate   = 1'b1;
`endif

  sap_ring_counter u_ring (
    .clk     (clk),
    .clr     (clr),
    .advance (advance),
    .freeze  (halted),
    .t_state (t_state)
  );

  // HLT is latched on the same edge that leaves T4, so the ring lands in T5 and stops there
  assign halt_set = advance && !halted && (t_state == S_T4) && (ir_opcode == OP_HLT);

  // Halt flag: set by HLT, cleared only by clr
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      halted <= 1'b0;
    end else if (halt_set) begin
      halted <= 1'b1;
    end
  end

  // Decode ring state and opcode into the control word; each state enables at most one bus driver
  always_comb begin
    ctrl = CTRL_IDLE;
    if (halted) begin
      // Tristate the MAR mux while halted
      ctrl.mar_g_n = 1'b1;
    end else begin
      case (t_state)
        S_T1: begin
          ctrl.pc_oe    = 1'b1;
          ctrl.mar_ld_n = 1'b0;
        end
        S_T2: begin
          ctrl.pc_inc = 1'b1;
        end
        S_T3: begin
          ctrl.ram_oe_n = 1'b0;
          ctrl.ir_ld_n  = 1'b0;
        end
        S_T4: begin
          case (ir_opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ctrl.ir_oe_n  = 1'b0;
              ctrl.mar_ld_n = 1'b0;
            end
            OP_OUT: begin
              ctrl.acc_oe   = 1'b1;
              ctrl.out_ld_n = 1'b0;
            end
            default: ;
          endcase
        end
        S_T5: begin
          case (ir_opcode)
            OP_LDA: begin
              ctrl.ram_oe_n = 1'b0;
              ctrl.acc_ld_n = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              ctrl.ram_oe_n = 1'b0;
              ctrl.b_ld_n   = 1'b0;
            end
            default: ;
          endcase
        end
        S_T6: begin
          case (ir_opcode)
            OP_ADD: begin
              ctrl.alu_oe   = 1'b1;
              ctrl.acc_ld_n = 1'b0;
            end
            OP_SUB: begin
              ctrl.alu_oe   = 1'b1;
              ctrl.alu_sub  = 1'b1;
              ctrl.acc_ld_n = 1'b0;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end

    if (!ld_gate) begin
      ctrl.pc_inc   = 1'b0;
      ctrl.mar_ld_n = 1'b1;
      ctrl.ir_ld_n  = 1'b1;
      ctrl.acc_ld_n = 1'b1;
      ctrl.b_ld_n   = 1'b1;
      ctrl.out_ld_n = 1'b1;
    end
  end

  assign pc_inc   = ctrl.pc_inc;
  assign pc_oe    = ctrl.pc_oe;
  assign mar_sel  = ctrl.mar_sel;
  assign mar_g_n  = ctrl.mar_g_n;
  assign mar_ld_n = ctrl.mar_ld_n;
  assign ram_oe_n = ctrl.ram_oe_n;
  assign ir_ld_n  = ctrl.ir_ld_n;
  assign ir_oe_n  = ctrl.ir_oe_n;
  assign acc_ld_n = ctrl.acc_ld_n;
  assign acc_oe   = ctrl.acc_oe;
  assign b_ld_n   = ctrl.b_ld_n;
  assign alu_sub  = ctrl.alu_sub;
  assign alu_oe   = ctrl.alu_oe;
  assign out_ld_n = ctrl.out_ld_n;

endmodule
